// File: rtl/shifter_right_seq_pkg.sv
// Shared types and sizing for the multicycle right shifter.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned DEF_WIDTH = 32;

  // Number of power-of-two stages needed to cover every shift amount.
  function automatic int unsigned shamt_w(input int unsigned w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/shifter_right_seq_if.sv
// Operand/result handshake bundle for shifter_right_seq.
interface shifter_right_seq_if
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);
  localparam int unsigned SHAMT_W = shamt_w(WIDTH);

  logic               start_valid;
  logic               start_ready;
  logic [WIDTH-1:0]   data_in;
  logic [SHAMT_W-1:0] shamt;
  logic               arith;
  logic [WIDTH-1:0]   result;
  logic               result_valid;
  logic               result_ready;

  // Issue side / consumer side.
  modport master (
    output start_valid, data_in, shamt, arith, result_ready,
    input  start_ready, result, result_valid
  );

  // The shifter itself.
  modport slave (
    input  start_valid, data_in, shamt, arith, result_ready,
    output start_ready, result, result_valid
  );
endinterface

// File: rtl/shifter_right_seq_stage.sv
// One power-of-two right-shift step: acc >> 2^k with fill bits on top.
module right_shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned SHAMT_W = shamt_w(WIDTH)
) (
  input  logic [WIDTH-1:0]   i_acc,
  input  logic [SHAMT_W-1:0] i_k,
  input  logic               i_fill,
  input  logic               i_en,
  output logic [WIDTH-1:0]   o_acc
);

  logic [SHAMT_W-1:0][WIDTH-1:0] w_stage;

  for (genvar g = 0; g < SHAMT_W; g++) begin : g_stage
    localparam int unsigned D = 1 << g;
    assign w_stage[g] = {{D{i_fill}}, i_acc[WIDTH-1:D]};
  end

  // Pick the candidate for stage k, or pass acc through when the bit is clear.
  always_comb begin
    o_acc = i_acc;
    for (int g = 0; g < SHAMT_W; g++)
      if (i_en && (i_k == SHAMT_W'(g))) o_acc = w_stage[g];
  end

endmodule

// File: rtl/shifter_right_seq.sv
// Multicycle SRL/SRA: one power-of-two stage per clock, largest stage first.
// Optional macro SHIFTER_RIGHT_SEQ_EARLY_EXIT_EN: finish as soon as no lower
// shift-amount bits remain set (shamt==0 still spends one SHIFT cycle).
module shifter_right_seq
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  shifter_right_seq_if.slave bus
);

  localparam int unsigned        SHAMT_W = shamt_w(WIDTH);
  localparam logic [SHAMT_W-1:0] K_TOP   = SHAMT_W'(SHAMT_W - 1);

  state_e             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_acc;
  logic [SHAMT_W-1:0] r_sh;
  logic [SHAMT_W-1:0] r_k;
  logic               r_fill;
  logic [WIDTH-1:0]   w_acc_nxt;
  logic               w_bit;
  logic               w_last;

  assign w_bit = |(r_sh & (SHAMT_W'(1) << r_k));

`ifdef SHIFTER_RIGHT_SEQ_EARLY_EXIT_EN
  logic [SHAMT_W-1:0] w_low;
  // Remaining shift bits below the current stage; none left means done.
  assign w_low  = r_sh & ((SHAMT_W'(1) << r_k) - SHAMT_W'(1));
  assign w_last = (w_low == '0);
`else
  assign w_last = (r_k == '0);
`endif

  right_shift_stage #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_stage (
    .i_acc  (r_acc),
    .i_k    (r_k),
    .i_fill (r_fill),
    .i_en   (w_bit),
    .o_acc  (w_acc_nxt)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state: accept in IDLE, step stages in SHIFT, hold result in DONE.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (bus.start_valid)  w_state_nxt = SHIFT;
      SHIFT:   if (w_last)           w_state_nxt = DONE;
      DONE:    if (bus.result_ready) w_state_nxt = IDLE;
      default:                       w_state_nxt = IDLE;
    endcase
  end

  // Datapath: load operand on accept, apply one stage per SHIFT cycle.
  // Fill is captured from the original sign so later stages never re-read acc.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc  <= '0;
      r_sh   <= '0;
      r_fill <= 1'b0;
      r_k    <= K_TOP;
    end else if (r_state == IDLE && bus.start_valid) begin
      r_acc  <= bus.data_in;
      r_sh   <= bus.shamt;
      r_fill <= bus.arith & bus.data_in[WIDTH-1];
      r_k    <= K_TOP;
    end else if (r_state == SHIFT) begin
      r_acc  <= w_acc_nxt;
      r_k    <= w_last ? K_TOP : r_k - SHAMT_W'(1);
    end
  end

  assign bus.start_ready  = (r_state == IDLE);
  assign bus.result_valid = (r_state == DONE);
  assign bus.result       = r_acc;

endmodule

// File: tb/tb_shifter_right_seq.sv
// Directed + random bench for shifter_right_seq with a reference model.
module tb_shifter_right_seq;
  import shift_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_q[$];
  time  last_acc_t;
  int   last_lat;
  logic tp_on = 1'b0;

  shifter_right_seq_if #(.WIDTH(32)) bus ();

  shifter_right_seq #(.WIDTH(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Reference: plain logical / arithmetic right shift.
  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] n, input logic a);
    if (a) return 32'($signed(d) >>> n);
    return d >> n;
  endfunction

  function automatic int exp_lat(input logic [4:0] n);
`ifdef SHIFTER_RIGHT_SEQ_EARLY_EXIT_EN
    if (n == 5'd0) return 1;
    for (int j = 0; j < 5; j++) if (n[j]) return 5 - j;
    return 5;
`else
    return 5;
`endif
  endfunction

  // Compare process: reset values while in reset, result vs model while valid.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_start_ready", 32'(bus.start_ready), 32'd1);
      chk("rst_result_valid", 32'(bus.result_valid), 32'd0);
      chk("rst_result", bus.result, 32'd0);
    end else if (bus.result_valid) begin
      if (exp_q.size() == 0) chk("spurious_valid", 32'(bus.result_valid), 32'd0);
      else begin
        chk("result", bus.result, exp_q[0]);
        if (bus.result_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic do_op(input logic [31:0] d, input logic [4:0] n, input logic a,
                       input logic [31:0] exp_v, input logic pin, input int hold);
    int  cnt;
    time t;
    if (pin) chk("model_pin", model(d, n, a), exp_v);
    @(negedge clk);
    bus.data_in = d; bus.shamt = n; bus.arith = a;
    bus.start_valid = 1'b1;
    bus.result_ready = (hold == 0);
    cnt = 0;
    while (!bus.start_ready && cnt < 20) begin @(negedge clk); cnt++; end
    if (!bus.start_ready) begin
      chk("accept_timeout", 32'(bus.start_ready), 32'd1);
      bus.start_valid = 1'b0;
      return;
    end
    exp_q.push_back(exp_v);
    @(posedge clk);
    t = $time;
    if (tp_on) chk("throughput", 32'((t - last_acc_t) / 10), 32'(last_lat + 2));
    last_acc_t = t;
    last_lat = exp_lat(n);
    #1;
    bus.start_valid = 1'b0;
    bus.data_in = ~d; bus.shamt = ~n; bus.arith = ~a;
    cnt = 0;
    do begin @(posedge clk); cnt++; #1; end while (!bus.result_valid && cnt < 20);
    chk("latency", 32'(cnt), 32'(exp_lat(n)));
    if (!bus.result_valid) begin exp_q.delete(); return; end
    chk("busy_start_ready", 32'(bus.start_ready), 32'd0);
    if (hold > 0) begin
      bus.start_valid = 1'b1;
      bus.data_in = 32'hDEAD_BEEF; bus.shamt = 5'd1; bus.arith = 1'b0;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("bp_result_valid", 32'(bus.result_valid), 32'd1);
      chk("bp_start_ready", 32'(bus.start_ready), 32'd0);
    end
    bus.start_valid = 1'b0;
    bus.result_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_hs_start_ready", 32'(bus.start_ready), 32'd1);
    chk("post_hs_result_valid", 32'(bus.result_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic [4:0]  n;
    logic        a;
    rst_n = 1'b0;
    bus.start_valid = 1'b0; bus.data_in = '0; bus.shamt = '0;
    bus.arith = 1'b0; bus.result_ready = 1'b0;
    #1;
    chk("init_start_ready", 32'(bus.start_ready), 32'd1);
    chk("init_result_valid", 32'(bus.result_valid), 32'd0);
    chk("init_result", bus.result, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with hand-computed results.
    do_op(32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 1'b1, 0);
    do_op(32'h8000_0000, 5'd4,  1'b1, 32'hF800_0000, 1'b1, 0);
    do_op(32'h7FFF_FFF0, 5'd4,  1'b1, 32'h07FF_FFFF, 1'b1, 0);
    do_op(32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678, 1'b1, 0);
    do_op(32'h1234_5678, 5'd0,  1'b1, 32'h1234_5678, 1'b1, 0);
    do_op(32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b1, 0);
    do_op(32'hF0F0_1234, 5'd16, 1'b0, 32'h0000_F0F0, 1'b1, 0);
    do_op(32'hF0F0_1234, 5'd16, 1'b1, 32'hFFFF_F0F0, 1'b1, 0);
    do_op(32'h8765_4321, 5'd1,  1'b1, 32'hC3B2_A190, 1'b1, 0);
    // Backpressure: result_ready low for 3 cycles in DONE.
    do_op(32'hCAFE_0000, 5'd12, 1'b1, 32'hFFFC_AFE0, 1'b1, 3);

    // Reset in the 3rd SHIFT cycle.
    @(negedge clk);
    bus.data_in = 32'hFFFF_FFFF; bus.shamt = 5'd1; bus.arith = 1'b0;
    bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_result_valid", 32'(bus.result_valid), 32'd0);
    chk("midrst_result", bus.result, 32'd0);
    chk("midrst_start_ready", 32'(bus.start_ready), 32'd1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_op(32'hFFFF_FFFF, 5'd8, 1'b0, 32'h00FF_FFFF, 1'b1, 0);

    // Random back-to-back operations against the model.
    for (int i = 0; i < 200; i++) begin
      d = $urandom;
      n = 5'($urandom_range(0, 31));
      a = 1'($urandom_range(0, 1));
      do_op(d, n, a, model(d, n, a), 1'b0, 0);
      tp_on = 1'b1;
    end

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/shifter_right_seq.md
# shifter_right_seq

Multicycle right shifter for the execute stage: logical (SRL) or arithmetic (SRA) shift of a 32-bit operand by a 5-bit amount. It applies one power-of-two stage per clock, from the shift-by-16 stage down to the shift-by-1 stage, using a registered accumulator. It complements the combinational left shifter and sits behind the ALU issue logic with valid/ready handshakes on the operand and result sides. One operation is in flight at a time.

## Interface
- WIDTH, 32, operand width; power of two, at least 2; SHAMT_W = log2(WIDTH) stages.
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start_valid  in  1  operand request.
- start_ready  out  1  block can accept a request; high only in IDLE.
- data_in  in  WIDTH  operand, sampled on accept.
- shamt  in  SHAMT_W  shift amount, sampled on accept.
- arith  in  1  sampled on accept; 1 = SRA (sign fill), 0 = SRL (zero fill).
- result  out  WIDTH  shifted value; valid while result_valid is high.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts the result.

## Operation
- States:
  - IDLE: start_ready=1.
  - SHIFT: stage index k counts down from SHAMT_W-1.
  - DONE: result_valid=1.
- IDLE → SHIFT on start_valid && start_ready. The accept edge loads:
  - acc ← data_in
  - sh ← shamt
  - fill ← arith & data_in[WIDTH-1]
  - k ← SHAMT_W-1
- SHIFT, each cycle:
  - if sh[k]: acc ← {2^k copies of fill, acc[WIDTH-1:2^k]}; else acc unchanged.
  - k ← k-1.
  - After stage 0 is applied, go to DONE.
- DONE → IDLE on result_ready. result_valid and result stay stable until then.
- start_valid is ignored outside IDLE; no queuing.
- result = acc at all times. It is only meaningful in DONE.
- The fill bit comes from the original operand sign, never from intermediate acc bits.
- Shift results by amount (mod 32 by width):
  - SRL by n gives data_in >> n.
  - SRA by n gives the sign-extended value; SRA of a negative operand by 31 = 0xFFFF_FFFF.
- Reset, including mid-operation: state=IDLE, acc=0, sh=0, fill=0, k=SHAMT_W-1.
- Output values during reset: start_ready=1, result_valid=0, result=0.

## Timing
- Latency, counted in rising edges from the accept edge to the edge where result_valid rises: SHAMT_W (5) for every shamt.
- Throughput with result_ready held high: one operation per SHAMT_W+2 cycles.
  - DONE lasts one cycle.
  - The return to IDLE lasts one cycle.
  - The next accept happens on the following edge.
- start_ready is registered: low from the edge after accept until the edge after the result handshake.
- No combinational path from inputs to outputs.

## Configuration
- Macro SHIFTER_RIGHT_SEQ_EARLY_EXIT_EN.
- Defined: SHIFT leaves to DONE right after the stage for the lowest set bit j of sh, skipping trailing zero stages.
  - Latency is SHAMT_W-j.
  - shamt==0 takes one SHIFT cycle with acc unchanged, so latency is 1.
- Not defined: latency is always SHAMT_W.
- Results are identical in both builds.

## Structure
- Package shift_pkg holds:
  - state encoding type {IDLE, SHIFT, DONE}
  - WIDTH default (32)
  - SHAMT_W function/constant
- Sub-module right_shift_stage: combinational shift of acc by 2^k with the fill bit, selected by k.
- The top level holds the FSM, the k counter and the registers.

## Test plan
- SRL 0x8000_0000 by 31, result_ready=1 → result 0x0000_0001; result_valid rises exactly 5 edges after accept.
- SRA 0x8000_0000 by 4 → 0xF800_0000. SRA 0x7FFF_FFF0 by 4 → 0x07FF_FFFF.
- shamt=0, operand 0x1234_5678, both arith values → 0x1234_5678.
  - Latency 5 without the macro, 1 with it.
  - With the macro, shamt=0x04 gives latency 3.
- Backpressure: result_ready=0 for 3 cycles in DONE.
  - result and result_valid stay stable; start_ready stays 0; a start_valid pulse meanwhile is not accepted.
  - After the handshake, start_ready=1 one edge later.
- Assert reset during the 3rd SHIFT cycle → result_valid=0, result=0, start_ready=1 immediately, with no clock needed. After release, SRL 0xFFFF_FFFF by 8 → 0x00FF_FFFF.
- 200 random back-to-back operations → every result matches the logical/arithmetic right-shift model.
